// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side valid/ready bus of the load/store unit.
// master = the unit itself (it initiates RAM accesses); slave = the core/RAM environment.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

interface load_store_unit_if #(
   parameter int ADDR_WIDTH = `RISCV_ADDR_WIDTH
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_size_i;
   logic                  req_unsigned_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [31:0]           req_wdata_i;
   logic                  resp_valid_o;
   logic [31:0]           resp_rdata_o;
   logic [1:0]            resp_err_o;
   logic                  mem_valid_o;
   logic                  mem_ready_i;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [3:0]            mem_we_o;
   logic [31:0]           mem_rdata_i;

   modport master (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  mem_ready_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output mem_ready_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Bridges one core load/store at a time onto the RAM valid/ready port, with lane
// steering, load extension, alignment checking and a read timeout.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module load_store_unit #(
   parameter int ADDR_WIDTH     = `RISCV_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   load_store_unit_if.master   bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                state_reg,      state_next;
   logic [1:0]            offset_reg,     offset_next;
   logic [1:0]            size_reg,       size_next;
   logic                  unsigned_reg,   unsigned_next;
   logic                  we_reg,         we_next;
   logic [7:0]            cnt_reg,        cnt_next;
   logic                  mem_valid_reg,  mem_valid_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg,   mem_addr_next;
   logic [31:0]           mem_wdata_reg,  mem_wdata_next;
   logic [3:0]            mem_we_reg,     mem_we_next;
   logic                  resp_valid_reg, resp_valid_next;
   logic [31:0]           resp_rdata_reg, resp_rdata_next;
   logic [1:0]            resp_err_reg,   resp_err_next;

   logic                  misaligned;
   logic [3:0]            byte_en;
   logic [31:0]           lane_wdata;
   logic [31:0]           lane;
   logic [31:0]           load_result;

   // Request decode, evaluated combinationally from the live request in IDLE.
   always_comb begin
      misaligned = 1'b0;
      byte_en    = 4'b1111;
      lane_wdata = bus.req_wdata_i;
      case (bus.req_size_i)
         2'b00: begin
            byte_en    = 4'b0001 << bus.req_addr_i[1:0];
            lane_wdata = {4{bus.req_wdata_i[7:0]}};
         end
         2'b01: begin
            misaligned = bus.req_addr_i[0];
            byte_en    = 4'b0011 << bus.req_addr_i[1:0];
            lane_wdata = {2{bus.req_wdata_i[15:0]}};
         end
         2'b10:   misaligned = (bus.req_addr_i[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Load extraction from the returned word using the latched offset/size.
   always_comb begin
      lane        = bus.mem_rdata_i >> {offset_reg, 3'b000};
      load_result = lane;
      case (size_reg)
         2'b00:   load_result = unsigned_reg ? {24'b0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
         2'b01:   load_result = unsigned_reg ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_result = lane;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      offset_next     = offset_reg;
      size_next       = size_reg;
      unsigned_next   = unsigned_reg;
      we_next         = we_reg;
      cnt_next        = cnt_reg;
      mem_valid_next  = 1'b0;
      mem_we_next     = 4'b0000;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      resp_valid_next = 1'b0;
      resp_rdata_next = resp_rdata_reg;
      resp_err_next   = resp_err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               offset_next   = bus.req_addr_i[1:0];
               size_next     = bus.req_size_i;
               unsigned_next = bus.req_unsigned_i;
               we_next       = bus.req_we_i;
               if (misaligned) begin
                  resp_valid_next = 1'b1;
                  resp_rdata_next = 32'h0;
                  resp_err_next   = 2'b01;
                  state_next      = ST_RESP;
               end else begin
                  mem_valid_next = 1'b1;
                  mem_addr_next  = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  mem_we_next    = bus.req_we_i ? byte_en : 4'b0000;
                  mem_wdata_next = lane_wdata;
                  state_next     = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // Writes are posted: the RAM never acknowledges them.
            if (we_reg) begin
               resp_valid_next = 1'b1;
               resp_rdata_next = 32'h0;
               resp_err_next   = 2'b00;
               state_next      = ST_RESP;
            end else begin
               cnt_next   = 8'd0;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_ready_i) begin
               resp_valid_next = 1'b1;
               resp_rdata_next = load_result;
               resp_err_next   = 2'b00;
               state_next      = ST_RESP;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               resp_valid_next = 1'b1;
               resp_rdata_next = 32'h0;
               resp_err_next   = 2'b10;
               state_next      = ST_RESP;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         offset_reg     <= 2'b00;
         size_reg       <= 2'b00;
         unsigned_reg   <= 1'b0;
         we_reg         <= 1'b0;
         cnt_reg        <= 8'd0;
         mem_valid_reg  <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= 32'h0;
         mem_we_reg     <= 4'b0000;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= 32'h0;
         resp_err_reg   <= 2'b00;
      end else begin
         state_reg      <= state_next;
         offset_reg     <= offset_next;
         size_reg       <= size_next;
         unsigned_reg   <= unsigned_next;
         we_reg         <= we_next;
         cnt_reg        <= cnt_next;
         mem_valid_reg  <= mem_valid_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         mem_we_reg     <= mem_we_next;
         resp_valid_reg <= resp_valid_next;
         resp_rdata_reg <= resp_rdata_next;
         resp_err_reg   <= resp_err_next;
      end
   end

   assign bus.req_ready_o  = (state_reg == ST_IDLE);
   assign bus.mem_valid_o  = mem_valid_reg;
   assign bus.mem_addr_o   = mem_addr_reg;
   assign bus.mem_wdata_o  = mem_wdata_reg;
   assign bus.mem_we_o     = mem_we_reg;
   assign bus.resp_valid_o = resp_valid_reg;
   assign bus.resp_rdata_o = resp_rdata_reg;
   assign bus.resp_err_o   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected RAM accesses
// and responses; independent monitors pop and compare whenever the DUT presents them.
module tb_load_store_unit;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic [1:0]  err;
      int          acc;
      int          lat;
   } resp_t;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      bit          chk_wd;
      int          acc;
   } memx_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   resp_t resp_q[$];
   memx_t mem_q[$];

   logic [31:0] mem [0:63];
   bit          stall = 1'b0;
   bit          late_req = 1'b0;

   load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

   load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // RAM model: zero-wait reads (ready one cycle after mem_valid), posted writes.
   initial begin
      logic        pend;
      logic [31:0] rd;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         pend = 1'b0;
         rd   = 32'h0;
         if (rst_n && bus.mem_valid_o) begin
            if (bus.mem_we_o != 4'b0000) begin
               for (int b = 0; b < 4; b++)
                  if (bus.mem_we_o[b]) mem[bus.mem_addr_o[7:2]][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
            end else if (!stall) begin
               pend = 1'b1;
               rd   = mem[bus.mem_addr_o[7:2]];
            end
         end
         @(posedge clk);
         #1;
         bus.mem_ready_i = pend | late_req;
         bus.mem_rdata_i = pend ? rd : 32'h5A5A5A5A;
         late_req = 1'b0;
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      resp_t r;
      if (rst_n && bus.resp_valid_o) begin
         if (resp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_resp: got resp_valid_o=1 (rdata=0x%08h err=%0d) expected none",
                     bus.resp_rdata_o, bus.resp_err_o);
         end else begin
            r = resp_q.pop_front();
            $display("resp %-14s rdata=0x%08h err=%0d latency=%0d", r.name, bus.resp_rdata_o,
                     bus.resp_err_o, cyc - r.acc);
            check({r.name, "_rdata"}, bus.resp_rdata_o, r.rdata);
            check({r.name, "_err"}, {30'b0, bus.resp_err_o}, {30'b0, r.err});
            check({r.name, "_lat"}, 32'(cyc - r.acc), 32'(r.lat));
         end
      end
   end

   // RAM-side monitor.
   always @(negedge clk) begin
      memx_t m;
      if (rst_n && bus.mem_valid_o) begin
         if (mem_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_mem: got mem_valid_o=1 addr=0x%08h we=%b expected none",
                     bus.mem_addr_o, bus.mem_we_o);
         end else begin
            m = mem_q.pop_front();
            $display("mem  %-14s addr=0x%08h we=%b wdata=0x%08h", m.name, bus.mem_addr_o,
                     bus.mem_we_o, bus.mem_wdata_o);
            check({m.name, "_maddr"}, bus.mem_addr_o, m.addr);
            check({m.name, "_mwe"}, {28'b0, bus.mem_we_o}, {28'b0, m.we});
            if (m.chk_wd) check({m.name, "_mwdata"}, bus.mem_wdata_o, m.wdata);
            check({m.name, "_mlat"}, 32'(cyc - m.acc), 32'd1);
         end
      end
   end

   task automatic issue(input string name, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_mem, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                        input bit exp_resp, input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input int lat);
      int t = 0;
      @(negedge clk);
      while (!bus.req_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept: got req_ready_o=0 for 50 cycles expected 1", name);
      end
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      if (exp_mem)
         mem_q.push_back('{name, {addr[31:2], 2'b00}, exp_we, exp_wd, we, cyc});
      if (exp_resp)
         resp_q.push_back('{name, exp_rd, exp_err, cyc, lat});
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = 32'hFFFF_FFFF;
      bus.req_wdata_i = 32'hCCCC_CCCC;
   endtask

   task automatic store(input string name, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] exp_we, input logic [31:0] exp_wd);
      issue(name, 1'b1, size, 1'b0, addr, wdata, 1'b1, exp_we, exp_wd, 1'b1, 32'h0, 2'b00, 2);
   endtask

   task automatic load(input string name, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] exp_rd);
      issue(name, 1'b0, size, uns, addr, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b1, exp_rd, 2'b00, 3);
   endtask

   task automatic bad(input string name, input bit we, input logic [1:0] size, input logic [31:0] addr);
      issue(name, we, size, 1'b0, addr, 32'h1111_2222, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 2'b01, 1);
   endtask

   initial begin
      int t;
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'b00;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 32'h0;
      bus.req_wdata_i    = 32'h0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
      check("rst_mem_valid", {31'b0, bus.mem_valid_o}, 32'd0);
      check("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata_o, 32'h0);
      check("rst_mem_addr", bus.mem_addr_o, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);

      store("st_word40", 2'b10, 32'h40, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      load ("ld_word40", 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);

      store("st_pattern", 2'b10, 32'h40, 32'h80F17F22, 4'b1111, 32'h80F17F22);
      load ("ld_sb43", 2'b00, 1'b0, 32'h43, 32'hFFFFFF80);
      load ("ld_ub43", 2'b00, 1'b1, 32'h43, 32'h00000080);
      load ("ld_sh42", 2'b01, 1'b0, 32'h42, 32'hFFFF80F1);
      load ("ld_sh40", 2'b01, 1'b0, 32'h40, 32'h00007F22);
      load ("ld_uh42", 2'b01, 1'b1, 32'h42, 32'h000080F1);
      load ("ld_sb41", 2'b00, 1'b0, 32'h41, 32'h0000007F);

      store("st_half46", 2'b01, 32'h46, 32'hFFFF1234, 4'b1100, 32'h12341234);
      store("st_byte45", 2'b00, 32'h45, 32'h000000AB, 4'b0010, 32'hABABABAB);
      load ("ld_word44", 2'b10, 1'b0, 32'h44, 32'h1234AB00);

      bad("mis_ldw42", 1'b0, 2'b10, 32'h42);
      bad("mis_sth41", 1'b1, 2'b01, 32'h41);
      bad("ill_size11", 1'b0, 2'b11, 32'h40);

      // Read timeout, then a stray ready pulse that must not produce a response.
      stall = 1'b1;
      issue("ld_timeout", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 4'b0000, 32'h0,
            1'b1, 32'h0, 2'b10, 6);
      repeat (7) @(negedge clk);
      check("to_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
      late_req = 1'b1;
      repeat (4) @(negedge clk);

      // Reset while the load sits in WAIT: everything clears, no response.
      issue("ld_reset", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 4'b0000, 32'h0,
            1'b0, 32'h0, 2'b00, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_mem_valid", {31'b0, bus.mem_valid_o}, 32'd0);
      check("mid_rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
      check("mid_rst_mem_we", {28'b0, bus.mem_we_o}, 32'd0);
      check("mid_rst_resp_err", {30'b0, bus.resp_err_o}, 32'd0);
      check("mid_rst_resp_rdata", bus.resp_rdata_o, 32'h0);
      check("mid_rst_mem_addr", bus.mem_addr_o, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
      load("ld_after_rst", 2'b10, 1'b0, 32'h40, 32'h80F17F22);

      t = 0;
      while ((resp_q.size() != 0 || mem_q.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (resp_q.size() != 0 || mem_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d responses and %0d accesses outstanding expected 0",
                  resp_q.size(), mem_q.size());
      end
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
